// File: rtl/riscv_pkg.sv
// Shared types for the program-image loader.
//   loader_state_t   : loader FSM states
//   LOADER_HDR_BYTES : bytes in the word-count header (also bytes per word)
package riscv_pkg;

  typedef enum logic [2:0] {
    HEADER,
    LOAD,
    RELEASE,
    DONE,
    ERROR
  } loader_state_t;

  localparam int LOADER_HDR_BYTES = 4;

endpackage

// File: rtl/imem_loader_byte_packer.sv
// Packs a little-endian byte stream into 32-bit words. Used for both the
// word-count header and the payload words.
//   clk, reset  : clock, synchronous active-high reset
//   clear       : drop any partially packed word
//   in_valid    : a byte is accepted this cycle
//   in_data     : the accepted byte
//   word        : packed word, valid together with word_valid
//   word_valid  : pulses on the cycle the 4th byte of a word is accepted
module byte_packer
  import riscv_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        clear,
  input  logic        in_valid,
  input  logic [7:0]  in_data,
  output logic [31:0] word,
  output logic        word_valid
);

  logic [1:0]  lane_q;
  logic [23:0] shift_q;

  // The newest byte lands on top, so after four bytes the first one sits in
  // bits [7:0]. The word is presented combinationally with the 4th byte so
  // the FSM can act on it in the same cycle.
  assign word       = {in_data, shift_q};
  assign word_valid = in_valid && (lane_q == 2'(LOADER_HDR_BYTES - 1));

  always_ff @(posedge clk) begin
    if (reset || clear) begin
      lane_q  <= '0;
      shift_q <= '0;
    end else if (in_valid) begin
      lane_q  <= lane_q + 2'd1;
      shift_q <= word[31:8];
    end
  end

endmodule

// File: rtl/imem_loader.sv
// Program-image loader: takes a byte stream (4-byte word count N, then N
// little-endian words), writes word k to BRAM address k over port b, and holds
// the core in reset until RELEASE_DELAY cycles after the last write.
//   clk, reset      : clock, synchronous active-high reset
//   s_valid/s_data  : byte stream in; s_ready accepts a byte
//   i_reload        : pulse; restart loading from DONE or ERROR
//   o_bram_addr     : word address for the write
//   o_bram_wr_data  : packed word
//   o_bram_wr_en    : byte enables, all lanes for one cycle per word
//   o_core_reset    : core reset request, low only in DONE
//   o_load_done     : image loaded and core released
//   o_error         : header word count exceeds BRAM capacity
//
// state   | meaning
// HEADER  | collecting the 4-byte word count
// LOAD    | collecting payload words, one write per 4 bytes
// RELEASE | counting down before releasing the core
// DONE    | core released, waiting for i_reload
// ERROR   | bad word count, core held in reset, waiting for i_reload
module imem_loader
  import riscv_pkg::*;
#(
  parameter int ADDR_WIDTH    = 10,
  parameter int NB_COL        = 4,
  parameter int COL_WIDTH     = 8,
  parameter int RELEASE_DELAY = 6
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        s_valid,
  input  logic [7:0]                  s_data,
  output logic                        s_ready,
  input  logic                        i_reload,
  output logic [ADDR_WIDTH-1:0]       o_bram_addr,
  output logic [NB_COL*COL_WIDTH-1:0] o_bram_wr_data,
  output logic [NB_COL-1:0]           o_bram_wr_en,
  output logic                        o_core_reset,
  output logic                        o_load_done,
  output logic                        o_error
);

  localparam int REL_W = $clog2(RELEASE_DELAY + 1);
  // Capacity held in 33 bits so the full 32-bit header compares correctly.
  localparam logic [32:0] MAX_WORDS = 33'(1) << ADDR_WIDTH;

  loader_state_t state_q, state_d;

  logic                        accept;
  logic                        reload_go;
  logic                        enter_release;
  logic                        write_word;
  logic [31:0]                 pk_word;
  logic                        pk_valid;
  logic [ADDR_WIDTH-1:0]       word_cnt_q;
  logic [ADDR_WIDTH-1:0]       last_idx_q;
  logic [REL_W-1:0]            rel_cnt_q;
  logic [ADDR_WIDTH-1:0]       addr_q;
  logic [NB_COL*COL_WIDTH-1:0] data_q;
  logic [NB_COL-1:0]           wr_en_q;

  assign s_ready    = (state_q == HEADER) || (state_q == LOAD);
  assign accept     = s_valid && s_ready;
  assign reload_go  = i_reload && ((state_q == DONE) || (state_q == ERROR));
  assign write_word = (state_q == LOAD) && pk_valid;

  byte_packer u_packer (
    .clk       (clk),
    .reset     (reset),
    .clear     (reload_go),
    .in_valid  (accept),
    .in_data   (s_data),
    .word      (pk_word),
    .word_valid(pk_valid)
  );

  always_comb begin
    state_d       = state_q;
    o_core_reset  = 1'b1;
    o_load_done   = 1'b0;
    o_error       = 1'b0;
    enter_release = 1'b0;
    case (state_q)
      HEADER: begin
        if (pk_valid) begin
          if (pk_word == '0) begin
            state_d       = RELEASE;
            enter_release = 1'b1;
          end else if ({1'b0, pk_word} > MAX_WORDS) begin
            state_d = ERROR;
          end else begin
            state_d = LOAD;
          end
        end
      end
      LOAD: begin
        if (pk_valid && (word_cnt_q == last_idx_q)) begin
          state_d       = RELEASE;
          enter_release = 1'b1;
        end
      end
      RELEASE: begin
        if (rel_cnt_q == '0) state_d = DONE;
      end
      DONE: begin
        o_core_reset = 1'b0;
        o_load_done  = 1'b1;
        if (i_reload) state_d = HEADER;
      end
      ERROR: begin
        o_error = 1'b1;
        if (i_reload) state_d = HEADER;
      end
      default: state_d = HEADER;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= HEADER;
      word_cnt_q <= '0;
      last_idx_q <= '0;
      rel_cnt_q  <= '0;
      addr_q     <= '0;
      data_q     <= '0;
      wr_en_q    <= '0;
    end else begin
      state_q <= state_d;
      wr_en_q <= '0;
      if ((state_q == HEADER) && pk_valid) begin
        word_cnt_q <= '0;
        // N <= capacity here, so N-1 always fits the address width.
        last_idx_q <= ADDR_WIDTH'(pk_word - 32'd1);
      end
      if (write_word) begin
        addr_q     <= word_cnt_q;
        data_q     <= pk_word;
        wr_en_q    <= '1;
        word_cnt_q <= word_cnt_q + 1'b1;
      end
      // Loaded with DELAY-1 on entry so DONE arrives DELAY cycles later.
      if (enter_release) begin
        rel_cnt_q <= REL_W'(RELEASE_DELAY - 1);
      end else if ((state_q == RELEASE) && (rel_cnt_q != '0)) begin
        rel_cnt_q <= rel_cnt_q - 1'b1;
      end
    end
  end

  assign o_bram_addr    = addr_q;
  assign o_bram_wr_data = data_q;
  assign o_bram_wr_en   = wr_en_q;

endmodule
